// File: rtl/ex_muldiv_if.sv
// Handshake bundle between the ID/EX stage and the iterative RV32M multiply/divide unit.
// The master side is the pipeline; the slave side is the unit.
interface ex_muldiv_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  E_Start;
    logic [2:0]            E_Funct3;
    logic [DATA_WIDTH-1:0] E_SrcA;
    logic [DATA_WIDTH-1:0] E_SrcB;
    logic                  E_Flush;
    logic                  E_Busy;
    logic                  E_Done;
    logic [DATA_WIDTH-1:0] E_MulDivResult;

    modport master (
        output E_Start, E_Funct3, E_SrcA, E_SrcB, E_Flush,
        input  E_Busy, E_Done, E_MulDivResult
    );

    modport slave (
        input  E_Start, E_Funct3, E_SrcA, E_SrcB, E_Flush,
        output E_Busy, E_Done, E_MulDivResult
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps on operand magnitudes,
// sign fix-up when the result is registered. Divide-by-zero and signed overflow finish in one cycle.
//
// state  | meaning
// S_IDLE | waiting for E_Start; launch cycle raises E_Busy combinationally
// S_CALC | one multiply/divide iteration per cycle, cnt_q 0..31
// S_DONE | E_Done pulse, result valid; always returns to S_IDLE
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    ex_muldiv_if.slave    mdu
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                  state_q;
    logic [2:0]              funct3_q;
    logic                    sign_a_q;
    logic                    sign_b_q;
    logic [DATA_WIDTH-1:0]   opd_q;
    logic [2*DATA_WIDTH-1:0] acc_q;
    logic [4:0]              cnt_q;
    logic [DATA_WIDTH-1:0]   result_q;

    logic                    is_div;
    logic                    signed_a;
    logic                    signed_b;
    logic                    a_neg;
    logic                    b_neg;
    logic [DATA_WIDTH-1:0]   a_mag;
    logic [DATA_WIDTH-1:0]   b_mag;
    logic                    div_zero;
    logic                    div_ovf;
    logic [DATA_WIDTH-1:0]   special_res;

    logic [DATA_WIDTH:0]     mul_sum;
    logic [2*DATA_WIDTH-1:0] mul_next;
    logic [DATA_WIDTH:0]     div_trial;
    logic [2*DATA_WIDTH-1:0] div_next;
    logic [2*DATA_WIDTH-1:0] acc_step;
    logic [2*DATA_WIDTH-1:0] prod_fix;
    logic [DATA_WIDTH-1:0]   quo;
    logic [DATA_WIDTH-1:0]   rem;
    logic [DATA_WIDTH-1:0]   final_res;

    // MULHSU treats only rs1 as signed; the unsigned forms all have funct3[0]=1 except MULH.
    always_comb begin
        is_div   = mdu.E_Funct3[2];
        signed_a = ~mdu.E_Funct3[0] | (mdu.E_Funct3 == 3'b001);
        signed_b = signed_a & (mdu.E_Funct3 != 3'b010);
        a_neg    = signed_a & mdu.E_SrcA[DATA_WIDTH-1];
        b_neg    = signed_b & mdu.E_SrcB[DATA_WIDTH-1];
        a_mag    = a_neg ? -mdu.E_SrcA : mdu.E_SrcA;
        b_mag    = b_neg ? -mdu.E_SrcB : mdu.E_SrcB;
        div_zero = is_div & (mdu.E_SrcB == '0);
        div_ovf  = is_div & ~mdu.E_Funct3[0]
                 & (mdu.E_SrcA == 32'h8000_0000) & (mdu.E_SrcB == 32'hFFFF_FFFF);
        if (div_zero)
            special_res = mdu.E_Funct3[1] ? mdu.E_SrcA : '1;
        else
            special_res = mdu.E_Funct3[1] ? '0 : 32'h8000_0000;
    end

    // Multiply keeps the multiplier in acc low half and shifts it out as the product shifts in;
    // divide keeps {remainder, dividend/quotient} in acc with the divisor in opd_q.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        mul_next  = {mul_sum, acc_q[DATA_WIDTH-1:1]};
        div_trial = acc_q[2*DATA_WIDTH-1:DATA_WIDTH-1] - {1'b0, opd_q};
        if (!div_trial[DATA_WIDTH])
            div_next = {div_trial[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b1};
        else
            div_next = {acc_q[2*DATA_WIDTH-2:0], 1'b0};
        acc_step  = funct3_q[2] ? div_next : mul_next;
        prod_fix  = (sign_a_q ^ sign_b_q) ? -acc_step : acc_step;
        quo       = acc_step[DATA_WIDTH-1:0];
        rem       = acc_step[2*DATA_WIDTH-1:DATA_WIDTH];
        case (funct3_q)
            3'b000:  final_res = prod_fix[DATA_WIDTH-1:0];
            3'b100:  final_res = (sign_a_q ^ sign_b_q) ? -quo : quo;
            3'b101:  final_res = quo;
            3'b110:  final_res = sign_a_q ? -rem : rem;
            3'b111:  final_res = rem;
            default: final_res = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            funct3_q <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opd_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (mdu.E_Flush) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mdu.E_Start) begin
                        funct3_q <= mdu.E_Funct3;
                        sign_a_q <= a_neg;
                        sign_b_q <= b_neg;
                        cnt_q    <= '0;
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            acc_q    <= '0;
                            state_q  <= S_DONE;
                        end else begin
                            opd_q   <= is_div ? b_mag : a_mag;
                            acc_q   <= {{DATA_WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_q <= final_res;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Busy is gated by rst so the stall request drops the instant reset is applied.
    assign mdu.E_Busy = ~rst & (((state_q == S_IDLE) & mdu.E_Start & ~mdu.E_Flush)
                              | (state_q == S_CALC));
    assign mdu.E_Done         = (state_q == S_DONE);
    assign mdu.E_MulDivResult = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected result and latency queued at launch,
// popped and compared when E_Done is observed.
module tb_ex_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    ex_muldiv_if #(.DATA_WIDTH(32)) mdu ();

    ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (mdu)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];
    logic [31:0] last_res = 32'h0;

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] a64, b64, p;
        logic        ovf;
        a64 = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) ? {{32{a[31]}}, a} : {32'h0, a};
        b64 = (f3 == 3'b000 || f3 == 3'b001) ? {{32{b[31]}}, b} : {32'h0, b};
        p   = a64 * b64;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b000:  return p[31:0];
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            3'b111:  return (b == 0) ? a : a % b;
            default: return p[63:32];
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Launch one operation and watch it to completion; returns observations only.
    task automatic do_op(input bit wait_first, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res, output int busy_n,
                         output int done_at, output logic extra);
        if (wait_first) @(negedge clk);
        mdu.E_Start  = 1'b1;
        mdu.E_Funct3 = f3;
        mdu.E_SrcA   = a;
        mdu.E_SrcB   = b;
        #1;
        busy_n  = mdu.E_Busy ? 1 : 0;
        done_at = -1;
        res     = 32'hxxxx_xxxx;
        extra   = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                mdu.E_Start = 1'b0;
                mdu.E_SrcA  = $urandom;
                mdu.E_SrcB  = $urandom;
            end
            @(negedge clk);
            if (mdu.E_Busy) busy_n++;
            if (mdu.E_Done) begin
                done_at  = k;
                res      = mdu.E_MulDivResult;
                last_res = res;
                break;
            end
        end
        if (done_at > 0) begin
            @(negedge clk);
            extra = mdu.E_Done;
        end
    endtask

    task automatic test_reset();
        mdu.E_Start  = 1'b1;
        mdu.E_Funct3 = 3'b000;
        mdu.E_SrcA   = 32'd1;
        mdu.E_SrcB   = 32'd1;
        mdu.E_Flush  = 1'b0;
        rst = 1'b1;
        #12;
        checks++;
        if (mdu.E_Busy !== 1'b0 || mdu.E_Done !== 1'b0 || mdu.E_MulDivResult !== 32'h0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b res=%h required 0/0/00000000",
                     mdu.E_Busy, mdu.E_Done, mdu.E_MulDivResult);
        end
        mdu.E_Start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mul_basic();
        logic [31:0] res, e;
        int busy_n, done_at, l;
        logic extra;
        exp_q.push_back(32'hFFFF_FFEB);
        lat_q.push_back(33);
        do_op(1'b1, 3'b000, 32'd7, 32'hFFFF_FFFD, res, busy_n, done_at, extra);
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        checks++;
        if (res !== e) begin failures++; $display("FAIL mul_result got=%h required=%h", res, e); end
        checks++;
        if (busy_n != l) begin failures++; $display("FAIL mul_busy_cycles got=%0d required=%0d", busy_n, l); end
        checks++;
        if (done_at != l) begin failures++; $display("FAIL mul_done_cycle got=L+%0d required=L+%0d", done_at, l); end
        checks++;
        if (extra !== 1'b0) begin failures++; $display("FAIL mul_done_pulse second_cycle_done=%b required=0", extra); end
    endtask

    task automatic test_table_ops();
        logic [2:0]  f3s[12] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111,
                                 3'b101, 3'b110, 3'b100, 3'b110, 3'b000};
        logic [31:0] as[12]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                                 32'h8000_0000, 32'h8000_0000, 32'h0001_0000};
        logic [31:0] bs[12]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'h0001_0000};
        logic [31:0] es[12]  = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                                 32'h8000_0000, 32'h0, 32'h0};
        int          ls[12]  = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 33};
        logic [31:0] res, e;
        int busy_n, done_at, l;
        logic extra;
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(es[i]);
            lat_q.push_back(ls[i]);
            do_op(1'b1, f3s[i], as[i], bs[i], res, busy_n, done_at, extra);
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            checks++;
            if (res !== e) begin failures++; $display("FAIL table%0d_result f3=%b got=%h required=%h", i, f3s[i], res, e); end
            checks++;
            if (busy_n != l || done_at != l) begin
                failures++;
                $display("FAIL table%0d_timing busy=%0d done=L+%0d required=%0d", i, busy_n, done_at, l);
            end
            checks++;
            if (extra !== 1'b0) begin failures++; $display("FAIL table%0d_pulse done_again=%b required=0", i, extra); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, res, e;
        int busy_n, done_at, l;
        logic extra;
        for (int i = 0; i < 16; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom >> $urandom_range(0, 28);
            exp_q.push_back(ref_res(f3, a, b));
            lat_q.push_back(ref_lat(f3, a, b));
            do_op(1'b1, f3, a, b, res, busy_n, done_at, extra);
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            checks++;
            if (res !== e || done_at != l) begin
                failures++;
                $display("FAIL rand%0d f3=%b a=%h b=%h got=%h@L+%0d required=%h@L+%0d",
                         i, f3, a, b, res, done_at, e, l);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, e;
        int busy_n, done_at, l;
        logic extra;
        exp_q.push_back(32'd42);  lat_q.push_back(33);
        exp_q.push_back(32'd6);   lat_q.push_back(33);
        do_op(1'b1, 3'b000, 32'd6, 32'd7, res, busy_n, done_at, extra);
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        checks++;
        if (res !== e || done_at != l) begin failures++; $display("FAIL b2b_first got=%h@L+%0d required=%h@L+%0d", res, done_at, e, l); end
        do_op(1'b0, 3'b101, 32'd42, 32'd7, res, busy_n, done_at, extra);
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        checks++;
        if (res !== e || done_at != l || busy_n != l) begin
            failures++;
            $display("FAIL b2b_second got=%h@L+%0d busy=%0d required=%h@L+%0d", res, done_at, busy_n, e, l);
        end
    endtask

    task automatic test_flush();
        logic [31:0] prev, res;
        int busy_n, done_at, pulses;
        logic extra;
        prev = last_res;
        @(negedge clk);
        mdu.E_Start  = 1'b1;
        mdu.E_Funct3 = 3'b000;
        mdu.E_SrcA   = 32'd5;
        mdu.E_SrcB   = 32'd9;
        @(posedge clk);
        #1 mdu.E_Start = 1'b0;
        repeat (9) @(posedge clk);
        #1 mdu.E_Flush = 1'b1;
        @(posedge clk);
        #1 mdu.E_Flush = 1'b0;
        @(negedge clk);
        checks++;
        if (mdu.E_Busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b required=0", mdu.E_Busy); end
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (mdu.E_Done) pulses++;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL flush_no_done got=%0d pulses required=0", pulses); end
        checks++;
        if (mdu.E_MulDivResult !== prev) begin failures++; $display("FAIL flush_hold got=%h required=%h", mdu.E_MulDivResult, prev); end
        exp_q.push_back(32'd12);
        do_op(1'b1, 3'b000, 32'd3, 32'd4, res, busy_n, done_at, extra);
        checks++;
        if (res !== exp_q[0] || done_at != 33) begin failures++; $display("FAIL flush_relaunch got=%h@L+%0d required=%h@L+33", res, done_at, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        mdu.E_Start  = 1'b1;
        mdu.E_Funct3 = 3'b101;
        mdu.E_SrcA   = 32'd1000;
        mdu.E_SrcB   = 32'd3;
        @(posedge clk);
        #1 mdu.E_Start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mdu.E_Busy !== 1'b0 || mdu.E_Done !== 1'b0 || mdu.E_MulDivResult !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid busy=%b done=%b res=%h required 0/0/00000000",
                     mdu.E_Busy, mdu.E_Done, mdu.E_MulDivResult);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mdu.E_Busy || mdu.E_Done || mdu.E_MulDivResult != 0) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL reset_stays_idle active_cycles=%0d required=0", seen); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul_basic();
        test_table_ops();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
